// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master and the SPI slave.
// Frame layout is [9:8] command, [7:0] address/data, sent MSB first.
package spi_pkg;

    localparam int unsigned SPI_FRAME_W = 10;
    localparam int unsigned SPI_RD_W    = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StChk,
        StShift,
        StRdWait,
        StRdShift,
        StGap
    } spi_state_e;

    // Only read-data frames keep SS_n low for a reply.
    function automatic logic is_rd_data(input logic [1:0] cmd);
        return cmd == CMD_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load register that shifts left by one bit per enabled cycle.
// The serial output is data[WIDTH-1]; shift_in enters at bit 0. Load wins over shift.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_RD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;

    // Register contents: synchronous clear, then load, then shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end else if (shift) begin
            data_q <= {data_q[WIDTH-2:0], shift_in};
        end
    end

    assign data = data_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: parallel command port to 10-bit-frame SPI master, same clock as the slave.
// Read-data frames keep SS_n low after the frame and collect an 8-bit MISO reply.
// Optional build macro SPI_MASTER_BUSY_EN adds the busy and frame_cnt outputs.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W  = SPI_FRAME_W,
    parameter int unsigned RD_W     = SPI_RD_W,
    parameter int unsigned MISO_DLY = 2,
    parameter int unsigned GAP      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [FRAME_W-1:0] cmd_data,
    output logic               cmd_ready,
    output logic               rsp_valid,
    output logic [RD_W-1:0]    rsp_data,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
`ifdef SPI_MASTER_BUSY_EN
    ,
    output logic               busy,
    output logic [15:0]        frame_cnt
`endif
);

    // Last count value in each timed state; one 4-bit counter serves them all.
    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
    localparam logic [3:0] RD_LAST    = 4'(RD_W - 1);
    localparam logic [3:0] DLY_LAST   = (MISO_DLY == 0) ? 4'd0 : 4'(MISO_DLY - 1);
    localparam logic [3:0] GAP_LAST   = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    spi_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       is_rd_q, is_rd_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [RD_W-1:0] rsp_data_q, rsp_data_d;

    logic               tx_load;
    logic               tx_shift;
    logic               rx_shift;
    logic [FRAME_W-1:0] tx_data;
    logic [RD_W-2:0]    rx_data;
    logic [FRAME_W-2:0] unused_tx_low;

    // Only the MSB of the TX register drives MOSI.
    assign unused_tx_low = tx_data[FRAME_W-2:0];

    spi_shift_reg #(
        .WIDTH (FRAME_W)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .load_data (cmd_data),
        .shift     (tx_shift),
        .shift_in  (1'b0),
        .data      (tx_data)
    );

    // Holds the first RD_W-1 reply bits; the last bit joins straight from MISO.
    spi_shift_reg #(
        .WIDTH (RD_W - 1)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rx_shift),
        .shift_in  (MISO),
        .data      (rx_data)
    );

    // Next state, counter and registered-output values; outputs follow the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_rd_d     = is_rd_q;
        tx_load     = 1'b0;
        rx_shift    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StChk;
                    cnt_d   = 4'd0;
                    tx_load = 1'b1;
                    is_rd_d = is_rd_data(cmd_data[FRAME_W-1 -: 2]);
                end
            end
            StChk: begin
                state_d = StShift;
                cnt_d   = 4'd0;
            end
            StShift: begin
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d = 4'd0;
                    if (!is_rd_q) begin
                        state_d = StGap;
                    end else if (MISO_DLY == 0) begin
                        state_d = StRdShift;
                    end else begin
                        state_d = StRdWait;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRdWait: begin
                if (cnt_q == DLY_LAST) begin
                    state_d = StRdShift;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRdShift: begin
                rx_shift = 1'b1;
                if (cnt_q == RD_LAST) begin
                    state_d     = StGap;
                    cnt_d       = 4'd0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {rx_data, MISO};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase

        // The CHK cycle repeats cmd[MSB]; every SHIFT entry sends then drops the TX MSB.
        tx_shift = (state_d == StShift);
        if (state_d == StChk) begin
            mosi_d = cmd_data[FRAME_W-1];
        end else if (state_d == StShift) begin
            mosi_d = tx_data[FRAME_W-1];
        end else begin
            mosi_d = 1'b0;
        end
        ss_n_d = (state_d == StIdle) || (state_d == StGap);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            is_rd_q     <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_rd_q     <= is_rd_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = rst_n && (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

`ifdef SPI_MASTER_BUSY_EN
    logic        busy_q;
    logic [15:0] frame_cnt_q;

    // Busy mirrors "not idle"; a frame counts as completed on entry to GAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            busy_q <= (state_d != StIdle);
            if ((state_d == StGap) && (state_q != StGap)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
`endif

endmodule
